// File: rtl/fib_arb_pkg.sv
// fib_arb_pkg: shared FSM state type, default sizing and overflow-bound helper for the fibonacci arbiter
package fib_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_MAX_N = 13;
  function automatic int max_n_for(input int width);
    longint a, b, t;
    int n;
    a = 0;
    b = 1;
    n = 1;
    for (int i = 0; i < 96; i++) begin
      t = a + b;
      if (t >= (longint'(1) << width)) break;
      a = b;
      b = t;
      n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/fib_req_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker, first request at or after ptr with wrap
module rr_grant #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  // scan from the farthest offset down so the nearest request overwrites
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = PW'((int'(ptr) + i) % N);
      end
  end
endmodule

// File: rtl/fib_req_arbiter.sv
// fib_req_arbiter: round-robin sharing of one fibonacci_gen among NUM_REQ requesters
module fib_req_arbiter
  import fib_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int GEN_LATENCY = 16,
  parameter int MAX_N       = DEF_MAX_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_n,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_fib,
  output logic                     resp_err,
  output logic                     gen_start,
  output logic [WIDTH-1:0]         gen_n,
  input  logic [WIDTH-1:0]         gen_fib
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(GEN_LATENCY) + 1;
  localparam logic [NUM_REQ-1:0] ONE = 1;
  state_t state, nxt;
  logic [PW-1:0] rr_ptr, own, gidx;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH-1:0] n_q, res_q, sel_n;
  logic err_q, acc, sel_err;
  logic [CW-1:0] cnt;

  rr_grant #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gidx)
  );

  assign sel_n   = req_n[gidx*WIDTH +: WIDTH];
  assign sel_err = int'(sel_n) > MAX_N;
  assign acc     = |req_ready;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = acc ? (sel_err ? RESP : ISSUE) : IDLE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (cnt == '0) ? RESP : WAIT;
      RESP:    nxt = resp_ready[own] ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end

  // ready is gated by reset so every output reads zero while reset is held
  always_comb begin
    req_ready  = (state == IDLE && rst) ? gnt : '0;
    gen_start  = state == ISSUE;
    gen_n      = (state == ISSUE || state == WAIT) ? n_q : '0;
    resp_valid = (state == RESP) ? ONE << own : '0;
    resp_fib   = (state == RESP && !err_q) ? res_q : '0;
    resp_err   = state == RESP && err_q;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr_ptr <= '0;
      own    <= '0;
      n_q    <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      if (acc) begin
        own    <= gidx;
        n_q    <= sel_n;
        err_q  <= sel_err;
        res_q  <= '0;
        rr_ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
      end
      if (state == ISSUE) cnt <= CW'(GEN_LATENCY - 1);
      if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) res_q <= gen_fib;
      end
    end
endmodule

// File: tb/tb_fib_req_arbiter.sv
// tb_fib_req_arbiter: scoreboard bench with a fixed-latency generator model
module tb_fib_req_arbiter;
  import fib_arb_pkg::*;
  localparam int NR = 4, W = 8, LAT = 16, MN = 13;
  typedef struct {int idx; int n; int fib; bit err; int lat;} item_t;
  logic clk = 0, rst = 0;
  logic [NR-1:0] req_valid = 0, req_ready, resp_valid, resp_ready = 0;
  logic [NR*W-1:0] req_n = 0;
  logic [W-1:0] resp_fib, gen_n, gen_fib;
  logic resp_err, gen_start;
  item_t exp_q[$];
  item_t it;
  int total = 0, bad = 0, cyc = 0, tmo = 0, acc_cyc = 0, gs_cnt = 0, acc_n = 0;
  int ptr_tag = 0, ptr_seen = 0, ptr_exp = 0, gc = 0;
  bit done = 0, init_chk = 0;
  logic [NR-1:0] keep = 0, prv_rv = 0;
  logic prv_hs = 0, prv_err = 0;
  logic [W-1:0] prv_fib = 0, gn = 0;

  fib_req_arbiter #(.NUM_REQ(NR), .WIDTH(W), .GEN_LATENCY(LAT), .MAX_N(MN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_fib(resp_fib), .resp_err(resp_err),
    .gen_start(gen_start), .gen_n(gen_n), .gen_fib(gen_fib)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] fib_of(input logic [W-1:0] n);
    logic [W-1:0] a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // generator stand-in: result is valid only in the single cycle before the capture edge
  always @(posedge clk)
    if (gen_start) begin
      gn <= gen_n;
      gc <= 1;
    end else if (gc != 0 && gc < 1000) gc <= gc + 1;
  assign gen_fib = (gc == LAT) ? fib_of(gn) : 8'hEE;

  task automatic chk(input string nm, input int act, input int ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, ex);
    end
  endtask

  always @(negedge clk) begin
    if (!init_chk) begin
      chk("max_n_fn", max_n_for(W), MN);
      init_chk = 1;
    end
    if (!rst) begin
      chk("rst_outputs", int'({req_ready, resp_valid, resp_fib, resp_err, gen_start, gen_n}), 0);
      exp_q.delete();
      prv_rv = 0;
      prv_hs = 0;
    end else begin
      if (|(req_valid & req_ready)) begin
        chk("ready_onehot", int'($onehot(req_ready)), 1);
        acc_cyc = cyc;
        gs_cnt = 0;
      end
      if (gen_start) begin
        gs_cnt++;
        chk("gen_start_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("gen_n", int'(gen_n), exp_q[0].n);
        chk("gen_start_lat", cyc - acc_cyc, 1);
      end
      if (|resp_valid && prv_rv == 0) begin
        chk("resp_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          it = exp_q.pop_front();
          chk("resp_owner", int'(resp_valid), 1 << it.idx);
          chk("resp_fib", int'(resp_fib), it.fib);
          chk("resp_err", int'(resp_err), int'(it.err));
          chk("resp_lat", cyc - acc_cyc, it.lat);
          chk("gen_starts", gs_cnt, it.err ? 0 : 1);
        end
      end else if (prv_rv != 0 && !prv_hs) begin
        chk("hold_valid", int'(resp_valid), int'(prv_rv));
        chk("hold_fib", int'(resp_fib), int'(prv_fib));
        chk("hold_err", int'(resp_err), int'(prv_err));
      end
      if (|resp_valid) chk("no_ready_in_resp", int'(req_ready), 0);
      prv_rv = resp_valid;
      prv_hs = |(resp_valid & resp_ready);
      prv_fib = resp_fib;
      prv_err = resp_err;
      if (ptr_tag != ptr_seen) begin
        chk("rr_ptr", int'(dut.rr_ptr), ptr_exp);
        chk("state_idle", int'(dut.state == IDLE), 1);
        ptr_seen = ptr_tag;
      end
      if (done) begin
        chk("queue_empty", exp_q.size(), 0);
        chk("timeouts", tmo, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  task automatic step();
    logic [NR-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    acc_n += $countones(hs);
    req_valid = req_valid & ~(hs & ~keep);
  endtask

  task automatic push(input int i, input int n, input int f, input bit e);
    exp_q.push_back('{idx: i, n: n, fib: f, err: e, lat: e ? 1 : LAT + 2});
  endtask

  task automatic req(input int i, input int n);
    req_n[i*W +: W] = W'(n);
    req_valid[i] = 1'b1;
  endtask

  task automatic run_until_idle(input int lim);
    for (int k = 0; k < lim; k++) begin
      if (exp_q.size() == 0 && resp_valid == 0 && req_valid == 0 && !gen_start) return;
      step();
    end
    tmo++;
  endtask

  task automatic ptr_chk(input int e);
    ptr_exp = e;
    ptr_tag++;
    step();
  endtask

  initial begin
    resp_ready = '1;
    repeat (3) step();
    rst = 1;
    step();
    push(0, 3, 2, 0); push(1, 4, 3, 0); push(2, 6, 8, 0); push(3, 13, 233, 0);
    req_n = {8'd13, 8'd6, 8'd4, 8'd3};
    req_valid = 4'b1111;
    run_until_idle(200);
    ptr_chk(0);
    push(0, 5, 5, 0);
    req(0, 5);
    run_until_idle(60);
    push(2, 14, 0, 1);
    req(2, 14);
    run_until_idle(20);
    ptr_chk(3);
    resp_ready = 4'b1101;
    push(1, 7, 13, 0);
    req(1, 7);
    for (int k = 0; k < 10 && req_valid != 0; k++) step();
    if (req_valid != 0) tmo++;
    push(3, 1, 1, 0);
    req(3, 1);
    for (int k = 0; k < 40 && resp_valid == 0; k++) step();
    if (resp_valid == 0) tmo++;
    repeat (10) step();
    resp_ready = '1;
    run_until_idle(80);
    push(0, 2, 1, 0); push(3, 8, 21, 0); push(0, 2, 1, 0); push(3, 8, 21, 0);
    req_n[0 +: W] = 8'd2;
    req_n[3*W +: W] = 8'd8;
    keep = 4'b1001;
    acc_n = 0;
    req_valid = 4'b1001;
    for (int k = 0; k < 200 && acc_n < 4; k++) step();
    if (acc_n < 4) tmo++;
    keep = 0;
    req_valid = 0;
    run_until_idle(80);
    ptr_chk(0);
    push(1, 9, 34, 0);
    req(1, 9);
    repeat (8) step();
    rst = 0;
    repeat (2) step();
    rst = 1;
    ptr_chk(0);
    push(2, 10, 55, 0);
    req(2, 10);
    run_until_idle(60);
    done = 1;
    repeat (5) step();
    $display("FAIL finish: monitor did not end the run");
    $fatal(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end
endmodule
